// File: rtl/cordic_sine_sequencer.sv
// cordic_sine_sequencer
// Folds a full-range angle in [-PI, PI] into [-HALF_PI, HALF_PI] (sine is
// preserved by the fold, so no output negation), runs one sine-core
// transaction, and returns the result with an error flag. Only one request
// is in flight at a time.
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   in_valid/in_ready    request handshake, in_angle is the full-range angle
//   core_start           one-cycle start pulse to the sine core
//   core_angle           folded angle, stable from accept until leaving WAIT
//   core_ready           core can accept a start
//   core_done/value      core result level and value
//   out_valid/out_ready  result handshake
//   out_value/out_err    sine result; err = range error or core timeout
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | waiting for core_ready, pulse core_start
// ARM   | discard a stale core_done left over from a previous operation
// WAIT  | waiting for core_done or timeout
// HOLD  | result presented until out_ready
module cordic_sine_sequencer #(
  parameter int                          BIT_WIDTH = 32,
  parameter logic signed [BIT_WIDTH-1:0] PI        = 32'sd1686629713,
  parameter logic signed [BIT_WIDTH-1:0] HALF_PI   = 32'sd843314857,
  parameter int                          TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] in_angle,
  output logic                        core_start,
  output logic signed [BIT_WIDTH-1:0] core_angle,
  input  logic                        core_ready,
  input  logic                        core_done,
  input  logic signed [BIT_WIDTH-1:0] core_value,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_value,
  output logic                        out_err
);

  localparam int            CW = $clog2(TIMEOUT + 1);
  // Last ARM/WAIT cycle: counter reads TIMEOUT-1 on the TIMEOUT-th cycle.
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, HOLD} state_t;

  state_t                        state;
  logic   [CW-1:0]               cnt;
  logic                          in_range;
  logic                          timed_out;
  logic   signed [BIT_WIDTH-1:0] folded;

  always_comb begin
    in_range = (in_angle <= PI) && (in_angle >= -PI);
    if (in_angle > HALF_PI)
      folded = PI - in_angle;
    else if (in_angle < -HALF_PI)
      folded = -PI - in_angle;
    else
      folded = in_angle;
  end

  assign timed_out = (cnt == TC);
  assign in_ready  = (state == IDLE);
  // Start must appear in the very cycle core_ready is first seen high, so it
  // is decoded from state and core_ready rather than registered.
  assign core_start = (state == ISSUE) && core_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      core_angle <= '0;
      out_valid  <= 1'b0;
      out_value  <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            core_angle <= folded;
            if (!in_range) begin
              out_value <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              out_err <= 1'b0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (core_ready) begin
            cnt   <= '0;
            state <= ARM;
          end
        end
        ARM: begin
          if (timed_out) begin
            out_value <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
            if (!core_done)
              state <= WAIT;
          end
        end
        WAIT: begin
          // Completion takes priority over a timeout in the same cycle.
          if (core_done) begin
            out_value <= core_value;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (timed_out) begin
            out_value <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sine_sequencer.sv
// Testbench for cordic_sine_sequencer: a behavioural sine-core stub with
// programmable latency, stale-done hold and no-response mode, driven by
// directed and randomized requests checked against a reference model.
module tb_cordic_sine_sequencer;

  localparam int     W      = 32;
  localparam longint PI_V   = 1686629713;
  localparam longint HALF_V = 843314857;
  localparam int     TMO    = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] in_angle = '0;
  logic core_start;
  logic signed [W-1:0] core_angle;
  logic core_ready = 1'b1;
  logic core_done = 1'b0;
  logic signed [W-1:0] core_value = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [W-1:0] out_value;
  logic out_err;

  int total = 0;
  int bad = 0;

  // stub controls and bookkeeping
  int stub_l = 2;
  int stub_s = 0;
  int stub_never = 0;
  logic signed [W-1:0] stub_val = '0;
  int stub_armed = 0;
  int stub_cnt = 0;
  int starts = 0;
  logic stub_st;

  always #5 clk = ~clk;

  cordic_sine_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_angle   (in_angle),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_ready (core_ready),
    .core_done  (core_done),
    .core_value (core_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_err    (out_err)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sine core stub: result appears stub_l cycles after the start cycle; an
  // old done is kept high for stub_s cycles after the start.
  always @(posedge clk) begin
    stub_st = core_start && core_ready;
    #1;
    if (stub_st) begin
      starts++;
      stub_armed = 1;
      stub_cnt = 0;
      if (stub_s == 0) core_done = 1'b0;
    end else if (stub_armed != 0) begin
      stub_cnt++;
      if (stub_cnt == stub_s) core_done = 1'b0;
      if (stub_never == 0 && stub_cnt == stub_l - 1) begin
        core_done = 1'b1;
        core_value = stub_val;
        stub_armed = 0;
      end
    end
  end

  function automatic longint fold(input longint a);
    if (a > HALF_V) return PI_V - a;
    if (a < -HALF_V) return -PI_V - a;
    return a;
  endfunction

  // a: angle, l: core latency, s: stale-done cycles, never: core silent,
  // r: cycles core_ready stays low, d: cycles out_ready stays low, v: core value
  task automatic run_txn(input longint a, input int l, input int s, input int never,
                         input int r, input int d, input longint v);
    bit     in_rng;
    longint exp_ang;
    longint exp_val;
    bit     exp_err;
    int     exp_lat;
    int     n;
    int     s0;
    int     busy_ready;
    int     unstable;
    logic signed [W-1:0] hv;
    logic   he;
    in_rng  = (a <= PI_V) && (a >= -PI_V);
    exp_ang = fold(a);
    if (!in_rng) begin
      exp_err = 1; exp_val = 0; exp_lat = 1;
    end else if (never == 0 && l <= TMO) begin
      exp_err = 0; exp_val = v; exp_lat = r + l + 2;
    end else begin
      exp_err = 1; exp_val = 0; exp_lat = r + TMO + 2;
    end
    stub_l = l; stub_s = s; stub_never = never; stub_val = W'(v);
    s0 = starts;
    busy_ready = 0;
    unstable = 0;

    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_angle = W'(a);
    core_ready = (r == 0);
    @(posedge clk);
    #1;
    // keep a request pending while busy; it must not be taken
    in_angle = W'($urandom);

    n = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("core_angle", core_angle, exp_ang);
      if (r > 0 && n == r + 1) begin
        chk("start_held", core_start, 0);
        core_ready = 1'b1;
        #1;
        chk("start_on_ready", core_start, in_rng);
      end
      if (out_valid) break;
      if (in_ready) busy_ready++;
    end
    in_valid = 1'b0;
    core_ready = 1'b1;
    chk("latency", n, exp_lat);
    chk("busy_ready", busy_ready, 0);
    chk("angle_stable", core_angle, exp_ang);
    chk("out_value", out_value, exp_val);
    chk("out_err", out_err, exp_err);
    chk("start_count", starts - s0, in_rng);

    hv = out_value;
    he = out_err;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (!out_valid || out_value !== hv || out_err !== he) unstable++;
    end
    chk("hold_stable", unstable, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  task automatic run_reset_mid();
    int seen;
    int s0;
    stub_l = 80; stub_s = 0; stub_never = 0; stub_val = W'(32'sd12345);
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = 32'sd536870912;
    core_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_core_start", core_start, 0);
    chk("rst_core_angle", core_angle, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_err", out_err, 0);
    @(negedge clk);
    reset = 1'b1;
    s0 = starts;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_valid", seen, 0);
    chk("rst_no_start", starts - s0, 0);
    chk("rst_ready", in_ready, 1);
  endtask

  initial begin
    int unsigned span;
    longint a;
    int l;
    int s;
    span = 32'd3373259426;

    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_value", out_value, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_core_start", core_start, 0);
    chk("reset_core_angle", core_angle, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);

    run_txn(0, 34, 0, 0, 0, 0, 0);
    run_txn(PI_V, 20, 0, 0, 0, 1, 32'sd77777);
    run_txn(-1264972285, 12, 1, 0, 0, 2, -32'sd5555);
    run_txn(PI_V + 1, 10, 0, 0, 0, 0, 99);
    run_txn(-PI_V - 1, 10, 0, 0, 0, 1, 99);
    run_txn(HALF_V, 5, 0, 0, 0, 0, 1234);
    run_txn(-HALF_V, 5, 0, 0, 0, 0, 4321);
    run_txn(HALF_V + 1, 7, 0, 0, 0, 0, 888);
    run_txn(1000, 10, 0, 1, 10, 0, 1);
    run_txn(2000, TMO, 0, 0, 0, 0, 424242);
    run_txn(3000, TMO + 1, 0, 0, 0, 0, 515151);
    run_txn(-7000, 9, 0, 0, 0, 0, 606);
    run_txn(9000, 30, 3, 0, 0, 5, 31337);

    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(5, 0) == 0) begin
        a = PI_V + 1 + longint'($urandom_range(1000, 0));
        if ($urandom_range(1, 0) == 1) a = -a;
      end else begin
        a = longint'($urandom_range(span, 0)) - PI_V;
      end
      l = $urandom_range(60, 2);
      s = $urandom_range((l - 2 > 3) ? 3 : l - 2, 0);
      run_txn(a, l, s, 0, $urandom_range(3, 0), $urandom_range(4, 0),
              longint'($signed(W'($urandom))));
    end

    run_reset_mid();
    run_txn(-1500000000, 15, 2, 0, 1, 1, 2024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_sine_sequencer.md
CORDIC_SINE_SEQUENCER -- requirements
Module: cordic_sine_sequencer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: width of all angle/value buses; must equal the sine core's BIT_WIDTH.
REQ-002 SHALL have parameter PI, default 32'sd1686629713: pi in the sine core's signed fixed-point angle format (Q3.29).
REQ-003 SHALL have parameter HALF_PI, default 32'sd843314857: pi/2 in the same format.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for the core before aborting; counter width = $clog2(TIMEOUT+1).
REQ-005 SHALL have port clk, input, 1: single clock; all state on posedge clk.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset (reset==0 resets).
REQ-007 SHALL have port in_valid, input, 1: request present.
REQ-008 SHALL have port in_ready, output, 1: sequencer accepts a request.
REQ-009 SHALL have port in_angle, input, BIT_WIDTH signed: full-range angle, legal range [-PI, PI].
REQ-010 SHALL have port core_start, output, 1: start pulse to sine core.
REQ-011 SHALL have port core_angle, output, BIT_WIDTH signed: reduced angle to sine core, within [-HALF_PI, HALF_PI].
REQ-012 SHALL have port core_ready, input, 1: sine core can accept start.
REQ-013 SHALL have port core_done, input, 1: sine core result valid (level, registered by core).
REQ-014 SHALL have port core_value, input, BIT_WIDTH signed: sine core result.
REQ-015 SHALL have port out_valid, output, 1: result present.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-017 SHALL have port out_value, output, BIT_WIDTH signed: sine of in_angle.
REQ-018 SHALL have port out_err, output, 1: result invalid (range error or timeout).

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, ARM, WAIT, HOLD; one request in flight at a time.
REQ-020 SHALL assert in_ready only in IDLE; accept on in_valid && in_ready.
REQ-021 On accept, SHALL register core_angle: a>HALF_PI -> PI-a; a<-HALF_PI -> -PI-a; else a (sine preserved, no output negation).
REQ-022 On accept with in_angle>PI or in_angle<-PI, SHALL skip the core, set out_value=0, out_err=1, go to HOLD.
REQ-023 Otherwise SHALL go IDLE->ISSUE with out_err=0.
REQ-024 In ISSUE, SHALL hold core_start=0 while core_ready=0; when core_ready=1 SHALL drive core_start=1 for exactly one cycle, then go to ARM.
REQ-025 core_angle SHALL remain stable from accept until leaving WAIT.
REQ-026 In ARM, SHALL ignore core_done until core_done==0 is sampled once (discards stale done), then go to WAIT.
REQ-027 In WAIT, on core_done==1 SHALL register out_value<=core_value, go to HOLD next cycle.
REQ-028 Timeout counter SHALL clear on ISSUE->ARM, increment each cycle in ARM/WAIT; on reaching TIMEOUT without capture SHALL set out_value=0, out_err=1, go to HOLD.
REQ-029 Completion and timeout in the same cycle: completion SHALL win (out_err=0).
REQ-030 In HOLD, out_valid=1 and out_value/out_err SHALL be stable until out_valid && out_ready, then go to IDLE.
REQ-031 out_valid SHALL be 0 in all states except HOLD; in_valid during non-IDLE states SHALL be ignored (no loss: in_ready=0).
REQ-032 Minimum latency, accept to out_valid, with core_ready=1: accept cycle + ISSUE + ARM + core latency + 1.

Reset
REQ-033 reset==0 SHALL immediately (asynchronously) force IDLE, core_start=0, core_angle=0, out_valid=0, out_value=0, out_err=0, counter=0; in_ready=1 after release.
REQ-034 Reset mid-operation SHALL abandon the request; a later core_done SHALL be ignored (ARM rule).

Verification
REQ-035 in_angle=0, core stub returns 0 after 34 cycles -> core_angle=0, one core_start pulse, out_value=0, out_err=0.
REQ-036 in_angle=1686629713 (PI) -> core_angle=0; in_angle=-1264972285 -> core_angle=-421657428; out_value equals stub core_value.
REQ-037 in_angle=1686629714 -> out_err=1, out_value=0, core_start never asserted, out_valid next cycle after accept.
REQ-038 core_ready held 0 for 10 cycles, then 1 -> core_start single pulse on first cycle core_ready=1; stub never asserts core_done -> out_err=1 after 255 cycles in ARM/WAIT.
REQ-039 core_done left high from prior op, out_ready held 0 for 5 cycles -> stale done ignored, out_value stable all 5 cycles, IDLE after handshake.
REQ-040 reset pulsed low in WAIT -> all outputs 0 same cycle; stub core_done afterward produces no out_valid.
